// File: rtl/node_bus_feeder.sv
`default_nettype none
// ============================================================================
// Module   : node_bus_feeder
// Purpose  : Buffers router blocks in a small FIFO and issues them onto one
//            of two tagged output buses under control of a command that
//            gives a base tag, a tag stride and a block count.
// Ports    : clk, rst (async, active-low)
//            cmd_valid/cmd_ready/cmd_tag/cmd_stride/cmd_count/cmd_port
//            in_valid/in_ready/in_data          - block input
//            tagA_OUT/d0_OUT, tagB_OUT/d1_OUT   - registered bus A / bus B
//            busy, done                         - status
// Revision : 1.0 - initial release
// ============================================================================
module node_bus_feeder #(
    parameter int DATA_WIDTH  = 16,
    parameter int BLOCK_WIDTH = 8 * DATA_WIDTH,
    parameter int TAG_WIDTH   = 16,
    parameter int DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [TAG_WIDTH-1:0]   cmd_tag,
    input  logic [TAG_WIDTH-1:0]   cmd_stride,
    input  logic [TAG_WIDTH-1:0]   cmd_count,
    input  logic                   cmd_port,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [BLOCK_WIDTH-1:0] in_data,
    output logic [TAG_WIDTH-1:0]   tagA_OUT,
    output logic [TAG_WIDTH-1:0]   tagB_OUT,
    output logic [BLOCK_WIDTH-1:0] d0_OUT,
    output logic [BLOCK_WIDTH-1:0] d1_OUT,
    output logic                   busy,
    output logic                   done
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_STREAM = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    // Reserved tag shown on a bus that is not carrying a block.
    localparam logic [TAG_WIDTH-1:0] c_IDLE_TAG = '1;

    // ------------------------------------------------------------------
    // FIFO storage and bookkeeping
    // ------------------------------------------------------------------
    logic [BLOCK_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]     r_wr_ptr;
    logic [c_PTR_W-1:0]     r_rd_ptr;
    logic [c_CNT_W-1:0]     r_count;

    // Command / issue state
    logic [1:0]             r_state;
    logic [TAG_WIDTH-1:0]   r_tag;
    logic [TAG_WIDTH-1:0]   r_stride;
    logic [TAG_WIDTH-1:0]   r_remaining;
    logic                   r_port;

    // Registered bus outputs
    logic [TAG_WIDTH-1:0]   r_tag_a;
    logic [TAG_WIDTH-1:0]   r_tag_b;
    logic [BLOCK_WIDTH-1:0] r_d0;
    logic [BLOCK_WIDTH-1:0] r_d1;

    logic                   w_full;
    logic                   w_empty;
    logic                   w_push;
    logic                   w_pop;
    logic                   w_cmd_accept;
    logic [c_PTR_W-1:0]     w_wr_ptr_nxt;
    logic [c_PTR_W-1:0]     w_rd_ptr_nxt;
    logic [BLOCK_WIDTH-1:0] w_pop_data;

    // Full/empty come straight from the occupancy register, so in_ready
    // never depends combinationally on anything on the output side.
    assign w_full       = (r_count == c_CNT_W'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_push       = in_valid & ~w_full;
    assign w_pop        = (r_state == c_STREAM) & ~w_empty;
    assign w_cmd_accept = cmd_valid & (r_state == c_IDLE);

    // Explicit wrap keeps the pointers correct for non-power-of-two depths.
    assign w_wr_ptr_nxt = (r_wr_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + c_PTR_W'(1);
    assign w_rd_ptr_nxt = (r_rd_ptr == c_PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + c_PTR_W'(1);
    assign w_pop_data   = r_mem[r_rd_ptr];

    // Payload storage carries no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_nxt;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_nxt;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Command FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= c_IDLE;
            r_tag       <= '0;
            r_stride    <= '0;
            r_remaining <= '0;
            r_port      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_cmd_accept) begin
                        if (cmd_count != '0) begin
                            r_tag       <= cmd_tag;
                            r_stride    <= cmd_stride;
                            r_remaining <= cmd_count;
                            r_port      <= cmd_port;
                            r_state     <= c_STREAM;
                        end else begin
                            r_state     <= c_DONE;
                        end
                    end
                end
                c_STREAM: begin
                    // An empty FIFO simply leaves tag and remaining untouched.
                    if (w_pop) begin
                        r_tag       <= r_tag + r_stride;
                        r_remaining <= r_remaining - TAG_WIDTH'(1);
                        if (r_remaining == TAG_WIDTH'(1)) begin
                            r_state <= c_DONE;
                        end
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Bus output registers: a popped block is visible for exactly the
    // cycle after its pop edge; otherwise both buses show the idle tag.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tag_a <= c_IDLE_TAG;
            r_tag_b <= c_IDLE_TAG;
            r_d0    <= '0;
            r_d1    <= '0;
        end else begin
            r_tag_a <= c_IDLE_TAG;
            r_tag_b <= c_IDLE_TAG;
            r_d0    <= '0;
            r_d1    <= '0;
            if (w_pop) begin
                if (r_port) begin
                    r_tag_b <= r_tag;
                    r_d1    <= w_pop_data;
                end else begin
                    r_tag_a <= r_tag;
                    r_d0    <= w_pop_data;
                end
            end
        end
    end

    assign tagA_OUT  = r_tag_a;
    assign tagB_OUT  = r_tag_b;
    assign d0_OUT    = r_d0;
    assign d1_OUT    = r_d1;
    assign cmd_ready = (r_state == c_IDLE);
    assign busy      = (r_state == c_STREAM);
    assign done      = (r_state == c_DONE);
    assign in_ready  = ~w_full;

endmodule
`default_nettype wire

// File: tb/tb_node_bus_feeder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_node_bus_feeder
// Purpose  : Self-checking bench for node_bus_feeder. A bus monitor compares
//            every issued block against a scoreboard built from the blocks
//            and commands the bench drives; directed sequences check timing.
// Revision : 1.0 - initial release
// ============================================================================
module tb_node_bus_feeder;

    localparam int BW = 128;
    localparam int TW = 16;
    localparam logic [TW-1:0] IDLE_TAG = 16'hFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [TW-1:0] cmd_tag;
    logic [TW-1:0] cmd_stride;
    logic [TW-1:0] cmd_count;
    logic          cmd_port;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic [TW-1:0] tagA_OUT;
    logic [TW-1:0] tagB_OUT;
    logic [BW-1:0] d0_OUT;
    logic [BW-1:0] d1_OUT;
    logic          busy;
    logic          done;

    always #5 clk = ~clk;

    node_bus_feeder dut (
        .clk        (clk),
        .rst        (rst),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_tag    (cmd_tag),
        .cmd_stride (cmd_stride),
        .cmd_count  (cmd_count),
        .cmd_port   (cmd_port),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .tagA_OUT   (tagA_OUT),
        .tagB_OUT   (tagB_OUT),
        .d0_OUT     (d0_OUT),
        .d1_OUT     (d1_OUT),
        .busy       (busy),
        .done       (done)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic          port;
        logic [TW-1:0] tag;
        logic [BW-1:0] data;
    } bus_t;

    typedef struct {
        logic [TW-1:0] tag;
        logic [TW-1:0] stride;
        logic          port;
        logic [TW-1:0] exp0;
        logic [TW-1:0] exp1;
    } vec_t;

    bus_t          sb[$];     // expected bus beats, in issue order
    logic [BW-1:0] mq[$];     // accepted blocks not yet assigned to a command
    logic [TW-1:0] mc_tag    = '0;
    logic [TW-1:0] mc_stride = '0;
    logic [TW-1:0] mc_rem    = '0;
    logic          mc_port   = 1'b0;

    function automatic logic [BW-1:0] mk(input logic [15:0] v);
        return {8{v}};
    endfunction

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pair buffered blocks with the active command to produce expected beats.
    function automatic void feed();
        bus_t e;
        while (mq.size() > 0 && mc_rem != '0) begin
            e.port = mc_port;
            e.tag  = mc_tag;
            e.data = mq.pop_front();
            sb.push_back(e);
            mc_tag = mc_tag + mc_stride;
            mc_rem = mc_rem - 16'd1;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string nm);
        check({nm, "_tagA"}, BW'(tagA_OUT), BW'(IDLE_TAG));
        check({nm, "_tagB"}, BW'(tagB_OUT), BW'(IDLE_TAG));
        check({nm, "_d0"}, d0_OUT, '0);
        check({nm, "_d1"}, d1_OUT, '0);
    endtask

    task automatic check_bus(input string nm, input logic port, input logic [TW-1:0] tag,
                             input logic [BW-1:0] data);
        check({nm, "_tag"},  BW'(port ? tagB_OUT : tagA_OUT), BW'(tag));
        check({nm, "_data"}, port ? d1_OUT : d0_OUT, data);
        check({nm, "_other_tag"},  BW'(port ? tagA_OUT : tagB_OUT), BW'(IDLE_TAG));
        check({nm, "_other_data"}, port ? d0_OUT : d1_OUT, '0);
    endtask

    task automatic push(input logic [BW-1:0] d);
        bit ok = 1'b0;
        int w  = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && w < 40) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
            w++;
        end
        in_valid = 1'b0;
        if (ok) begin
            mq.push_back(d);
            feed();
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: in_ready stayed %0b, expected 1", in_ready);
        end
    endtask

    task automatic send_cmd(input logic [TW-1:0] tag, input logic [TW-1:0] stride,
                            input logic [TW-1:0] count, input logic port);
        bit ok = 1'b0;
        int w  = 0;
        cmd_valid  = 1'b1;
        cmd_tag    = tag;
        cmd_stride = stride;
        cmd_count  = count;
        cmd_port   = port;
        while (!ok && w < 40) begin
            @(negedge clk);
            ok = cmd_ready;
            @(posedge clk);
            #1;
            w++;
        end
        cmd_valid = 1'b0;
        if (ok) begin
            mc_tag    = tag;
            mc_stride = stride;
            mc_rem    = count;
            mc_port   = port;
            feed();
        end else begin
            n_checks++;
            n_fail++;
            $display("FAIL cmd_timeout: cmd_ready stayed %0b, expected 1", cmd_ready);
        end
    endtask

    // Bus monitor: any non-idle beat must be the next scoreboard entry.
    always @(posedge clk) begin
        bus_t e;
        #1;
        if (tagA_OUT !== IDLE_TAG || d0_OUT !== '0 || tagB_OUT !== IDLE_TAG || d1_OUT !== '0) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_unexpected: tagA %0h tagB %0h, expected both %0h", tagA_OUT, tagB_OUT, IDLE_TAG);
            end else begin
                e = sb.pop_front();
                check("sb_tag",  BW'(e.port ? tagB_OUT : tagA_OUT), BW'(e.tag));
                check("sb_data", e.port ? d1_OUT : d0_OUT, e.data);
                check("sb_other_tag", BW'(e.port ? tagA_OUT : tagB_OUT), BW'(IDLE_TAG));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[5];
        logic [BW-1:0] blk0;
        logic [BW-1:0] blk1;

        vecs[0] = '{tag: 16'hFFF8, stride: 16'h0008, port: 1'b0, exp0: 16'hFFF8, exp1: 16'h0000};
        vecs[1] = '{tag: 16'h1234, stride: 16'h0001, port: 1'b1, exp0: 16'h1234, exp1: 16'h1235};
        vecs[2] = '{tag: 16'h0000, stride: 16'h8000, port: 1'b1, exp0: 16'h0000, exp1: 16'h8000};
        vecs[3] = '{tag: 16'h7FFF, stride: 16'hFFFF, port: 1'b0, exp0: 16'h7FFF, exp1: 16'h7FFE};
        vecs[4] = '{tag: 16'h0100, stride: 16'h0000, port: 1'b0, exp0: 16'h0100, exp1: 16'h0100};

        cmd_valid  = 1'b0;
        cmd_tag    = '0;
        cmd_stride = '0;
        cmd_count  = '0;
        cmd_port   = 1'b0;
        in_valid   = 1'b0;
        in_data    = '0;
        rst        = 1'b1;
        #2 rst = 1'b0;

        // Reset values, while held and after release
        #10;
        check("rst_cmd_ready", BW'(cmd_ready), 1);
        check("rst_in_ready",  BW'(in_ready), 1);
        check("rst_busy",      BW'(busy), 0);
        check("rst_done",      BW'(done), 0);
        check_idle("rst");
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_cmd_ready", BW'(cmd_ready), 1);
        check("post_rst_done",      BW'(done), 0);
        check_idle("post_rst");

        // Three buffered blocks streamed on bus A back-to-back
        push(mk(16'hD000));
        push(mk(16'hD001));
        push(mk(16'hD002));
        send_cmd(16'h0010, 16'h0004, 16'd3, 1'b0);
        check("s1_busy", BW'(busy), 1);
        check("s1_cmd_ready", BW'(cmd_ready), 0);
        check_idle("s1_pre");
        tick(); check_bus("s1_b0", 1'b0, 16'h0010, mk(16'hD000)); check("s1_done0", BW'(done), 0);
        tick(); check_bus("s1_b1", 1'b0, 16'h0014, mk(16'hD001)); check("s1_done1", BW'(done), 0);
        tick(); check_bus("s1_b2", 1'b0, 16'h0018, mk(16'hD002));
        check("s1_done2", BW'(done), 1);
        check("s1_busy2", BW'(busy), 0);
        tick(); check("s1_done3", BW'(done), 0); check("s1_cmd_ready3", BW'(cmd_ready), 1);
        check_idle("s1_post");

        // Table of two-block commands: tag arithmetic, wrap, port select
        for (int i = 0; i < 5; i++) begin
            blk0 = mk(16'(16'hA000 + 2 * i));
            blk1 = mk(16'(16'hA001 + 2 * i));
            push(blk0);
            push(blk1);
            send_cmd(vecs[i].tag, vecs[i].stride, 16'd2, vecs[i].port);
            tick(); check_bus("vec_first", vecs[i].port, vecs[i].exp0, blk0);
            check("vec_done_first", BW'(done), 0);
            tick(); check_bus("vec_second", vecs[i].port, vecs[i].exp1, blk1);
            check("vec_done", BW'(done), 1);
            tick(); check("vec_done_clear", BW'(done), 0);
            check("vec_cmd_ready", BW'(cmd_ready), 1);
        end

        // Command before data: stalls hold the tag, one block every 3rd cycle
        send_cmd(16'h0500, 16'h0003, 16'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            push(mk(16'(16'hB000 + i)));
            tick();
            check_bus("stall_issue", 1'b1, 16'(16'h0500 + 3 * i), mk(16'(16'hB000 + i)));
            check("stall_done", BW'(done), (i == 3) ? 1 : 0);
            tick();
            check_idle("stall_gap");
            check("stall_busy", BW'(busy), (i == 3) ? 0 : 1);
            check("stall_done_gap", BW'(done), 0);
        end

        // FIFO full: fifth block waits until a command frees an entry
        for (int i = 0; i < 4; i++) begin
            push(mk(16'(16'hE000 + i)));
        end
        check("full_in_ready", BW'(in_ready), 0);
        in_valid = 1'b1;
        in_data  = mk(16'hE004);
        tick();
        check("full_hold_in_ready", BW'(in_ready), 0);
        check_idle("full_hold");
        cmd_valid  = 1'b1;
        cmd_tag    = 16'h2000;
        cmd_stride = 16'h0010;
        cmd_count  = 16'd5;
        cmd_port   = 1'b0;
        tick();
        cmd_valid = 1'b0;
        mc_tag = 16'h2000; mc_stride = 16'h0010; mc_rem = 16'd5; mc_port = 1'b0;
        feed();
        check("full_accept_in_ready", BW'(in_ready), 0);
        tick();
        check_bus("full_b0", 1'b0, 16'h2000, mk(16'hE000));
        check("full_freed_in_ready", BW'(in_ready), 1);
        tick();
        in_valid = 1'b0;
        mq.push_back(mk(16'hE004));
        feed();
        check_bus("full_b1", 1'b0, 16'h2010, mk(16'hE001));
        for (int i = 2; i < 5; i++) begin
            tick();
            check_bus("full_bn", 1'b0, 16'(16'h2000 + 16 * i), mk(16'(16'hE000 + i)));
        end
        check("full_done", BW'(done), 1);
        tick(); check("full_done_clear", BW'(done), 0);

        // Zero-count command: done one cycle after accept, no bus activity
        send_cmd(16'h0042, 16'h0001, 16'd0, 1'b1);
        check("zero_done", BW'(done), 1);
        check("zero_busy", BW'(busy), 0);
        check("zero_cmd_ready", BW'(cmd_ready), 0);
        check_idle("zero");
        tick();
        check("zero_done_clear", BW'(done), 0);
        check("zero_cmd_ready_back", BW'(cmd_ready), 1);

        // Reset mid-command after two of four blocks
        for (int i = 0; i < 4; i++) begin
            push(mk(16'(16'hC000 + i)));
        end
        send_cmd(16'h3000, 16'h0001, 16'd4, 1'b0);
        tick(); check_bus("mid_b0", 1'b0, 16'h3000, mk(16'hC000));
        tick(); check_bus("mid_b1", 1'b0, 16'h3001, mk(16'hC001));
        #2 rst = 1'b0;
        #1;
        sb.delete();
        mq.delete();
        mc_rem = '0;
        check_idle("mid_rst");
        check("mid_rst_busy", BW'(busy), 0);
        check("mid_rst_done", BW'(done), 0);
        check("mid_rst_cmd_ready", BW'(cmd_ready), 1);
        check("mid_rst_in_ready", BW'(in_ready), 1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mid_rst_no_done", BW'(done), 0);
        end
        rst = 1'b1;
        tick();
        check("mid_post_done", BW'(done), 0);
        push(mk(16'hD00D));
        send_cmd(16'h4000, 16'h0001, 16'd1, 1'b1);
        tick();
        check_bus("mid_new", 1'b1, 16'h4000, mk(16'hD00D));
        check("mid_new_done", BW'(done), 1);
        tick();
        check_idle("mid_new_post");
        check("mid_new_done_clear", BW'(done), 0);

        tick();
        check("sb_drained", BW'(sb.size()), 0);
        check("mq_drained", BW'(mq.size()), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
